// File: rtl/vx_vgpr_collector_pkg.sv
// Shared configuration and VGPR request/response packing for the operand collector.
// Field order of the structs matches the VGPR unit's bus packing.
package vx_vgpr_collector_pkg;

    localparam int NUM_OPDS   = 3;
    localparam int VL_COUNT   = 4;
    localparam int SIMD_WIDTH = 4;
    localparam int XLEN       = 32;
    localparam int REG_BITS   = 5;
    localparam int WIS_W      = 2;
    localparam int SID_W      = 1;
    localparam int TAG_W      = 8;

    localparam int OPD_W  = (NUM_OPDS > 1) ? $clog2(NUM_OPDS) : 1;
    localparam int VL_W   = (VL_COUNT > 1) ? $clog2(VL_COUNT) : 1;
    localparam int BEAT_W = SIMD_WIDTH * XLEN;
    localparam int TOT_W  = $clog2(NUM_OPDS * VL_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } col_state_e;

    typedef struct packed {
        logic [OPD_W-1:0]    opd;
        logic [VL_W-1:0]     lid;
        logic [WIS_W-1:0]    wis;
        logic [SID_W-1:0]    sid;
        logic [REG_BITS-1:0] regid;
    } vgpr_req_t;

    typedef struct packed {
        logic [OPD_W-1:0]  opd;
        logic [BEAT_W-1:0] data;
    } vgpr_rsp_t;

    function automatic int popcount(input logic [NUM_OPDS-1:0] m);
        popcount = 0;
        for (int i = 0; i < NUM_OPDS; i++) popcount += int'(m[i]);
    endfunction

endpackage

// File: rtl/vx_vgpr_collector_req_seq.sv
// Request cursor: walks used operands in ascending order with lid inner,
// presents one read at a time under valid/ready and pulses o_done on the last handshake.
module vx_vgpr_req_seq #(
    parameter int NUM_OPDS = 3,
    parameter int VL_COUNT = 4,
    parameter int OPD_W    = 2,
    parameter int VL_W     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [NUM_OPDS-1:0] i_used,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [OPD_W-1:0]    o_opd,
    output logic [VL_W-1:0]     o_lid,
    output logic                o_done
);

    localparam logic [VL_W-1:0] LID_LAST = VL_W'(VL_COUNT - 1);

    logic                r_active;
    logic [NUM_OPDS-1:0] r_used;
    logic [OPD_W-1:0]    r_opd;
    logic [VL_W-1:0]     r_lid;

    logic             w_fire;
    logic             w_last_lid;
    logic             w_has_nxt;
    logic [OPD_W-1:0] w_nxt_opd;
    logic [OPD_W-1:0] w_first_opd;

    // Descending scan so the lowest qualifying index is the one that sticks.
    always_comb begin
        w_nxt_opd   = '0;
        w_has_nxt   = 1'b0;
        w_first_opd = '0;
        for (int i = NUM_OPDS - 1; i >= 0; i--) begin
            if (r_used[i] && (OPD_W'(i) > r_opd)) begin
                w_nxt_opd = OPD_W'(i);
                w_has_nxt = 1'b1;
            end
            if (i_used[i]) w_first_opd = OPD_W'(i);
        end
    end

    assign w_fire     = r_active && i_ready;
    assign w_last_lid = (r_lid == LID_LAST);
    assign o_done     = w_fire && w_last_lid && !w_has_nxt;
    assign o_valid    = r_active;
    assign o_opd      = r_opd;
    assign o_lid      = r_lid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_used   <= '0;
            r_opd    <= '0;
            r_lid    <= '0;
        end else if (i_start) begin
            r_active <= |i_used;
            r_used   <= i_used;
            r_opd    <= w_first_opd;
            r_lid    <= '0;
        end else if (w_fire) begin
            if (w_last_lid) begin
                r_lid <= '0;
                if (w_has_nxt) r_opd <= w_nxt_opd;
                else           r_active <= 1'b0;
            end else begin
                r_lid <= r_lid + VL_W'(1);
            end
        end
    end

endmodule

// File: rtl/vx_vgpr_collector.sv
// Operand-collector slot: issues VGPR reads for one instruction's sources,
// gathers the beats into an operand buffer and hands the full set downstream.
module vx_vgpr_collector
    import vx_vgpr_collector_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIS_W-1:0]                     in_wis,
    input  logic [SID_W-1:0]                     in_sid,
    input  logic [NUM_OPDS*REG_BITS-1:0]         in_rs,
    input  logic [NUM_OPDS-1:0]                  in_used,
    input  logic [TAG_W-1:0]                     in_tag,
    output logic                                 req_valid,
    input  logic                                 req_ready,
    output logic [OPD_W-1:0]                     req_opd,
    output logic [VL_W-1:0]                      req_lid,
    output logic [WIS_W-1:0]                     req_wis,
    output logic [SID_W-1:0]                     req_sid,
    output logic [REG_BITS-1:0]                  req_reg,
    input  logic                                 rsp_valid,
    input  logic [OPD_W-1:0]                     rsp_opd,
    input  logic [BEAT_W-1:0]                    rsp_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TAG_W-1:0]                     out_tag,
    output logic [NUM_OPDS*VL_COUNT*BEAT_W-1:0]  out_data,
    output logic                                 busy
);

    localparam logic [VL_W:0]  CNT_MAX = (VL_W+1)'(VL_COUNT);
    localparam logic [VL_W:0]  CNT_ONE = (VL_W+1)'(1);
    localparam logic [OPD_W:0] OPD_LIM = (OPD_W+1)'(NUM_OPDS);

    col_state_e                                   r_state;
    logic                                         r_in_ready;
    logic                                         r_out_valid;
    logic                                         r_busy;
    logic [WIS_W-1:0]                             r_wis;
    logic [SID_W-1:0]                             r_sid;
    logic [NUM_OPDS-1:0][REG_BITS-1:0]            r_rs;
    logic [NUM_OPDS-1:0]                          r_used;
    logic [TAG_W-1:0]                             r_tag;
    logic [NUM_OPDS-1:0][VL_COUNT-1:0][BEAT_W-1:0] r_buf;
    logic [NUM_OPDS-1:0][VL_W:0]                  r_cnt;
    logic [TOT_W-1:0]                             r_tot;
    logic [TOT_W-1:0]                             r_exp;

    logic             w_seq_start;
    logic             w_seq_valid;
    logic             w_seq_done;
    logic [OPD_W-1:0] w_seq_opd;
    logic [VL_W-1:0]  w_seq_lid;
    logic             w_rsp_ok;
    logic [TOT_W-1:0] w_tot_nxt;
    vgpr_req_t        w_req;
    vgpr_rsp_t        w_rsp;

    assign w_seq_start = (r_state == ST_IDLE) && in_valid && (|in_used);

    vx_vgpr_req_seq #(
        .NUM_OPDS (NUM_OPDS),
        .VL_COUNT (VL_COUNT),
        .OPD_W    (OPD_W),
        .VL_W     (VL_W)
    ) u_req_seq (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_seq_start),
        .i_used  (in_used),
        .o_valid (w_seq_valid),
        .i_ready (req_ready),
        .o_opd   (w_seq_opd),
        .o_lid   (w_seq_lid),
        .o_done  (w_seq_done)
    );

    assign w_req = '{opd: w_seq_opd, lid: w_seq_lid, wis: r_wis, sid: r_sid, regid: r_rs[w_seq_opd]};
    assign req_valid = w_seq_valid;
    assign req_opd   = w_req.opd;
    assign req_lid   = w_req.lid;
    assign req_wis   = w_req.wis;
    assign req_sid   = w_req.sid;
    assign req_reg   = w_req.regid;

    // Malformed responses (idle, unused operand, overflow) are dropped, not stored.
    assign w_rsp    = '{opd: rsp_opd, data: rsp_data};
    assign w_rsp_ok = rsp_valid && (r_state != ST_IDLE) && ({1'b0, w_rsp.opd} < OPD_LIM)
                      && r_used[w_rsp.opd] && (r_cnt[w_rsp.opd] < CNT_MAX);
    assign w_tot_nxt = r_tot + TOT_W'(w_rsp_ok);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_tag   = r_tag;
    assign out_data  = r_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_used      <= '0;
            r_cnt       <= '0;
            r_tot       <= '0;
            r_exp       <= '0;
        end else begin
            if (w_rsp_ok) begin
                r_buf[w_rsp.opd][r_cnt[w_rsp.opd][VL_W-1:0]] <= w_rsp.data;
                r_cnt[w_rsp.opd] <= r_cnt[w_rsp.opd] + CNT_ONE;
            end
            r_tot <= w_tot_nxt;

            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_wis      <= in_wis;
                        r_sid      <= in_sid;
                        r_rs       <= in_rs;
                        r_used     <= in_used;
                        r_tag      <= in_tag;
                        r_buf      <= '0;
                        r_cnt      <= '0;
                        r_tot      <= '0;
                        r_exp      <= TOT_W'(popcount(in_used) * VL_COUNT);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (|in_used) begin
                            r_state <= ST_REQ;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (w_seq_done) r_state <= ST_WAIT;
                end
                // Compare the post-increment count so the last beat completes this edge.
                ST_WAIT: begin
                    if (w_tot_nxt == r_exp) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    a_rsp_idle: assert property (@(posedge clk) disable iff (reset)
        rsp_valid |-> (r_state != ST_IDLE));
    a_rsp_used: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && (r_state != ST_IDLE)) |-> r_used[rsp_opd]);
    a_rsp_ovf: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && (r_state != ST_IDLE)) |-> (r_cnt[rsp_opd] < CNT_MAX));

endmodule

// File: tb/tb_vx_vgpr_collector.sv
// Directed bench for the VGPR operand collector with an echo responder of selectable latency.
module tb_vx_vgpr_collector;
    import vx_vgpr_collector_pkg::*;

    localparam int OD_W = VL_COUNT * BEAT_W;

    logic                                clk = 1'b0;
    logic                                reset = 1'b1;
    logic                                in_valid = 1'b0;
    logic                                in_ready;
    logic [WIS_W-1:0]                    in_wis = '0;
    logic [SID_W-1:0]                    in_sid = '0;
    logic [NUM_OPDS*REG_BITS-1:0]        in_rs = '0;
    logic [NUM_OPDS-1:0]                 in_used = '0;
    logic [TAG_W-1:0]                    in_tag = '0;
    logic                                req_valid;
    logic                                req_ready = 1'b1;
    logic [OPD_W-1:0]                    req_opd;
    logic [VL_W-1:0]                     req_lid;
    logic [WIS_W-1:0]                    req_wis;
    logic [SID_W-1:0]                    req_sid;
    logic [REG_BITS-1:0]                 req_reg;
    logic                                rsp_valid;
    logic [OPD_W-1:0]                    rsp_opd;
    logic [BEAT_W-1:0]                   rsp_data;
    logic                                out_valid;
    logic                                out_ready = 1'b0;
    logic [TAG_W-1:0]                    out_tag;
    logic [NUM_OPDS*VL_COUNT*BEAT_W-1:0] out_data;
    logic                                busy;

    vx_vgpr_collector dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wis(in_wis), .in_sid(in_sid),
        .in_rs(in_rs), .in_used(in_used), .in_tag(in_tag),
        .req_valid(req_valid), .req_ready(req_ready), .req_opd(req_opd), .req_lid(req_lid),
        .req_wis(req_wis), .req_sid(req_sid), .req_reg(req_reg),
        .rsp_valid(rsp_valid), .rsp_opd(rsp_opd), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [OD_W-1:0] got, input logic [OD_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] beat(input int opd, input int rid, input int lid);
        beat = '0;
        for (int l = 0; l < SIMD_WIDTH; l++)
            beat[l*XLEN +: XLEN] = XLEN'({8'(rid), 8'(opd), 8'(lid), 8'(192 + l)});
    endfunction

    function automatic logic [OD_W-1:0] exp_opd(input logic [NUM_OPDS-1:0] used,
                                                input logic [NUM_OPDS*REG_BITS-1:0] rs, input int o);
        exp_opd = '0;
        if (used[o])
            for (int l = 0; l < VL_COUNT; l++)
                exp_opd[l*BEAT_W +: BEAT_W] = beat(o, int'(rs[o*REG_BITS +: REG_BITS]), l);
    endfunction

    // Echo responder: replays each accepted request after 1 or 2 cycles.
    typedef struct packed {
        logic                v;
        logic [OPD_W-1:0]    opd;
        logic [VL_W-1:0]     lid;
        logic [REG_BITS-1:0] rid;
    } pend_t;

    pend_t d1 = '0;
    pend_t d2 = '0;
    pend_t rp;
    int    rsp_dly = 2;

    always @(posedge clk) begin
        if (reset) begin
            d1 <= '0;
            d2 <= '0;
        end else begin
            d1 <= '{v: req_valid && req_ready, opd: req_opd, lid: req_lid, rid: req_reg};
            d2 <= d1;
        end
    end

    assign rp        = (rsp_dly == 1) ? d1 : d2;
    assign rsp_valid = rp.v;
    assign rsp_opd   = rp.opd;
    assign rsp_data  = beat(int'(rp.opd), int'(rp.rid), int'(rp.lid));

    logic       rdy_tgl = 1'b0;
    always @(negedge clk) req_ready = rdy_tgl ? ~req_ready : 1'b1;

    // Request log and stall-stability monitor.
    logic [31:0] obs [0:127];
    int          n_obs = 0;
    int          n_rsp = 0;
    int          n_stall = 0;
    int          n_hold_bad = 0;
    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] w_cur;
    assign w_cur = 32'({req_opd, req_lid, req_wis, req_sid, req_reg});

    always @(posedge clk) begin
        if (reset) begin
            stalled <= 1'b0;
        end else begin
            if (rsp_valid) n_rsp <= n_rsp + 1;
            if (stalled && (!req_valid || w_cur != held)) n_hold_bad <= n_hold_bad + 1;
            if (req_valid && req_ready) begin
                obs[n_obs % 128] <= w_cur;
                n_obs <= n_obs + 1;
            end
            if (req_valid && !req_ready) n_stall <= n_stall + 1;
            stalled <= req_valid && !req_ready;
            held    <= w_cur;
        end
    end

    task automatic run(input logic [NUM_OPDS-1:0] used, input logic [NUM_OPDS*REG_BITS-1:0] rs,
                       input logic [TAG_W-1:0] tag, input int dly, input int lat, input int hold);
        int          base;
        int          cyc;
        int          n_exp;
        logic [31:0] e;
        rsp_dly = dly;
        base    = n_obs;
        @(negedge clk);
        chk("accept_in_ready", OD_W'(in_ready), OD_W'(1));
        in_valid = 1'b1;
        in_used  = used;
        in_rs    = rs;
        in_tag   = tag;
        in_wis   = WIS_W'(tag);
        in_sid   = SID_W'(tag >> WIS_W);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        chk("busy_after_accept", OD_W'(busy), OD_W'(1));
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("out_valid", OD_W'(out_valid), OD_W'(1));
        if (lat > 0) chk("latency", OD_W'(cyc), OD_W'(lat));
        chk("out_tag", OD_W'(out_tag), OD_W'(tag));
        for (int o = 0; o < NUM_OPDS; o++)
            chk($sformatf("out_data_opd%0d", o), out_data[o*OD_W +: OD_W], exp_opd(used, rs, o));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_used  = '1;
            in_tag   = ~tag;
            chk("hold_in_ready", OD_W'(in_ready), OD_W'(0));
            chk("hold_out_valid", OD_W'(out_valid), OD_W'(1));
            chk("hold_out_tag", OD_W'(out_tag), OD_W'(tag));
            for (int o = 0; o < NUM_OPDS; o++)
                chk($sformatf("hold_data_opd%0d", o), out_data[o*OD_W +: OD_W], exp_opd(used, rs, o));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_out_valid", OD_W'(out_valid), OD_W'(0));
        chk("post_in_ready", OD_W'(in_ready), OD_W'(1));
        n_exp = 0;
        for (int o = 0; o < NUM_OPDS; o++) begin
            if (used[o]) begin
                for (int l = 0; l < VL_COUNT; l++) begin
                    e = 32'({OPD_W'(o), VL_W'(l), WIS_W'(tag), SID_W'(tag >> WIS_W),
                             rs[o*REG_BITS +: REG_BITS]});
                    chk($sformatf("req_o%0d_l%0d", o, l), OD_W'(obs[(base + n_exp) % 128]), OD_W'(e));
                    n_exp++;
                end
            end
        end
        chk("req_count", OD_W'(n_obs - base), OD_W'(n_exp));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st0;
        int r0;
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", OD_W'(in_ready), OD_W'(1));
        chk("rst_req_valid", OD_W'(req_valid), OD_W'(0));
        chk("rst_out_valid", OD_W'(out_valid), OD_W'(0));
        chk("rst_busy", OD_W'(busy), OD_W'(0));
        reset = 1'b0;

        // Two operands with a gap, 2-cycle responder: 8 reads, done at T11.
        run(3'b101, {5'd7, 5'd0, 5'd3}, 8'h35, 2, 11, 0);
        // Single operand minimum latency.
        run(3'b001, {5'd0, 5'd0, 5'd9}, 8'h12, 2, 7, 0);

        // Alternating req_ready stalls.
        st0 = n_stall;
        rdy_tgl = 1'b1;
        run(3'b101, {5'd7, 5'd0, 5'd3}, 8'h4C, 2, 0, 0);
        rdy_tgl = 1'b0;
        chk("stalls_seen", OD_W'(n_stall > st0), OD_W'(1));
        chk("req_hold_stable", OD_W'(n_hold_bad), OD_W'(0));

        // No operands: straight to DONE.
        run(3'b000, {5'd1, 5'd2, 5'd3}, 8'hA7, 2, 1, 0);
        // Downstream backpressure for 5 cycles with a competing in_valid.
        run(3'b110, {5'd17, 5'd4, 5'd30}, 8'h5E, 2, 11, 5);
        // 1-cycle responder: a beat lands on the REQ->WAIT edge.
        run(3'b001, {5'd0, 5'd0, 5'd21}, 8'h9B, 1, 6, 0);

        // Reset in WAIT after 3 of 4 responses.
        rsp_dly = 2;
        r0 = n_rsp;
        @(negedge clk);
        in_valid = 1'b1;
        in_used  = 3'b001;
        in_rs    = {5'd0, 5'd0, 5'd13};
        in_tag   = 8'h66;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while ((n_rsp - r0) < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_rsp_count", OD_W'(n_rsp - r0), OD_W'(3));
        chk("mid_busy", OD_W'(busy), OD_W'(1));
        chk("mid_out_valid", OD_W'(out_valid), OD_W'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", OD_W'(in_ready), OD_W'(1));
        chk("abort_req_valid", OD_W'(req_valid), OD_W'(0));
        chk("abort_out_valid", OD_W'(out_valid), OD_W'(0));
        chk("abort_busy", OD_W'(busy), OD_W'(0));
        reset = 1'b0;
        run(3'b111, {5'd2, 5'd11, 5'd31}, 8'hF0, 2, 15, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
